// File: rtl/enc4to2_req_pkg.sv
// Shared widths and code constants for the 4-to-2 request encoder.
package enc4to2_req_pkg;
    localparam int CODE_W = 2;
    localparam int REQ_W  = 4;

    typedef logic [CODE_W-1:0] code_t;
    typedef logic [REQ_W-1:0]  req_t;

    localparam code_t C0 = 2'd0;
    localparam code_t C1 = 2'd1;
    localparam code_t C2 = 2'd2;
    localparam code_t C3 = 2'd3;
endpackage

// File: rtl/enc4to2_req_if.sv
// Request/code bus between the producer, the encoder and its consumer.
interface enc4to2_req_if;
    import enc4to2_req_pkg::*;

    logic  E;
    req_t  req;
    logic  ready;
    logic  a;
    logic  b;
    logic  valid;
    req_t  pend;
    logic  ovf;

    modport master (output E, req, ready, input a, b, valid, pend, ovf);
    modport slave  (input E, req, ready, output a, b, valid, pend, ovf);
endinterface

// File: rtl/enc4to2_req_pri_sel4.sv
// Combinational 4-input priority picker; direction chosen by LSB_FIRST.
module enc4to2_req_pri_sel4
    import enc4to2_req_pkg::*;
#(
    parameter bit LSB_FIRST = 1'b0
) (
    input  req_t  in,
    output code_t sel,
    output logic  any
);
    assign any = |in;

    generate
        if (LSB_FIRST) begin : g_lsb
            always_comb begin
                if      (in[0]) sel = C0;
                else if (in[1]) sel = C1;
                else if (in[2]) sel = C2;
                else            sel = C3;
            end
        end else begin : g_msb
            always_comb begin
                if      (in[3]) sel = C3;
                else if (in[2]) sel = C2;
                else if (in[1]) sel = C1;
                else            sel = C0;
            end
        end
    endgenerate
endmodule

// File: rtl/enc4to2_req.sv
// Registered priority request encoder: queues request events as pending bits
// and issues one 2-bit code at a time over a valid/ready handshake.
module enc4to2_req
    import enc4to2_req_pkg::*;
#(
    parameter bit LSB_FIRST = 1'b0
) (
    input logic             clk,
    input logic             rst_n,
    enc4to2_req_if.slave    bus
);
    req_t  pend_q;
    code_t code_q;
    logic  valid_q;
    logic  ovf_q;

    logic  accept, slot, issue, any;
    req_t  cand, sel_oh;
    code_t sel;

    assign accept = valid_q & bus.ready;
    assign slot   = ~valid_q | accept;
    // Requests arriving this cycle compete directly, giving one-cycle latency.
    assign cand   = pend_q | bus.req;
    assign issue  = slot & bus.E & any;
    assign sel_oh = req_t'(1) << sel;

    enc4to2_req_pri_sel4 #(.LSB_FIRST(LSB_FIRST)) u_sel (
        .in  (cand),
        .sel (sel),
        .any (any)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pend_q  <= '0;
            code_q  <= '0;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            pend_q  <= cand & ~(issue ? sel_oh : req_t'(0));
            if (issue)
                code_q <= sel;
            valid_q <= issue | (valid_q & ~accept);
            ovf_q   <= |(bus.req & pend_q);
        end
    end

    assign bus.a     = code_q[0];
    assign bus.b     = code_q[1];
    assign bus.valid = valid_q;
    assign bus.pend  = pend_q;
    assign bus.ovf   = ovf_q;
endmodule

// File: tb/tb_enc4to2_req.sv
// Directed bench for enc4to2_req (MSB-first priority).
module tb_enc4to2_req;
    logic clk = 1'b0;
    logic rst_n;
    int   total = 0;
    int   failed = 0;

    enc4to2_req_if bus_if ();

    enc4to2_req #(.LSB_FIRST(1'b0)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if.slave)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        total++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic v, input logic [1:0] code,
                           input logic [3:0] p, input logic o);
        chk({tag, ".valid"}, {3'b0, bus_if.valid}, {3'b0, v});
        chk({tag, ".code"},  {2'b0, bus_if.b, bus_if.a}, {2'b0, code});
        chk({tag, ".pend"},  bus_if.pend, p);
        chk({tag, ".ovf"},   {3'b0, bus_if.ovf}, {3'b0, o});
    endtask

    initial begin
        // 1 reset with all requests asserted
        rst_n = 1'b0; bus_if.E = 1'b1; bus_if.ready = 1'b0; bus_if.req = 4'hF;
        tick(); tick();
        chk_all("rst", 1'b0, 2'd0, 4'h0, 1'b0);
        rst_n = 1'b1; bus_if.req = 4'h0;
        tick();
        chk_all("rst_rel", 1'b0, 2'd0, 4'h0, 1'b0);

        // 2 single request
        bus_if.ready = 1'b1; bus_if.req = 4'b0100;
        tick();
        chk_all("single", 1'b1, 2'd2, 4'h0, 1'b0);
        bus_if.req = 4'h0;
        tick();
        chk_all("single_drain", 1'b0, 2'd2, 4'h0, 1'b0);

        // 3 priority under back-pressure
        bus_if.ready = 1'b0; bus_if.req = 4'b1011;
        tick();
        chk_all("bp0", 1'b1, 2'd3, 4'b0011, 1'b0);
        bus_if.req = 4'h0;
        tick(); chk_all("bp1", 1'b1, 2'd3, 4'b0011, 1'b0);
        tick(); chk_all("bp2", 1'b1, 2'd3, 4'b0011, 1'b0);
        bus_if.ready = 1'b1;
        tick(); chk_all("seq1", 1'b1, 2'd1, 4'b0001, 1'b0);
        tick(); chk_all("seq0", 1'b1, 2'd0, 4'b0000, 1'b0);
        tick(); chk_all("seq_end", 1'b0, 2'd0, 4'b0000, 1'b0);

        // 4 overflow on merge into pending bit
        bus_if.ready = 1'b0; bus_if.req = 4'b1010;
        tick(); chk_all("ovf_setup", 1'b1, 2'd3, 4'b0010, 1'b0);
        bus_if.req = 4'b0010;
        tick(); chk_all("ovf_pulse", 1'b1, 2'd3, 4'b0010, 1'b1);
        bus_if.req = 4'h0;
        tick(); chk_all("ovf_clear", 1'b1, 2'd3, 4'b0010, 1'b0);
        bus_if.ready = 1'b1;
        tick(); chk_all("ovf_drain1", 1'b1, 2'd1, 4'b0000, 1'b0);
        tick(); chk_all("ovf_drain2", 1'b0, 2'd1, 4'b0000, 1'b0);

        // back-to-back: accept and new request in the same cycle
        bus_if.req = 4'b1000;
        tick(); chk_all("b2b0", 1'b1, 2'd3, 4'b0000, 1'b0);
        bus_if.req = 4'b0001;
        tick(); chk_all("b2b1", 1'b1, 2'd0, 4'b0000, 1'b0);
        bus_if.req = 4'h0;
        tick(); chk_all("b2b_end", 1'b0, 2'd0, 4'b0000, 1'b0);

        // 5 issue enable
        bus_if.E = 1'b0; bus_if.req = 4'b0001;
        tick(); chk_all("en_off", 1'b0, 2'd0, 4'b0001, 1'b0);
        bus_if.req = 4'h0;
        tick(); chk_all("en_hold", 1'b0, 2'd0, 4'b0001, 1'b0);
        bus_if.E = 1'b1;
        tick(); chk_all("en_on", 1'b1, 2'd0, 4'b0000, 1'b0);
        tick(); chk_all("en_drain", 1'b0, 2'd0, 4'b0000, 1'b0);

        // 6 reset while a code is held and bits are pending
        bus_if.ready = 1'b0; bus_if.req = 4'b0100;
        tick(); chk_all("mid_setup", 1'b1, 2'd2, 4'b0000, 1'b0);
        bus_if.req = 4'b1001;
        tick(); chk_all("mid_pend", 1'b1, 2'd2, 4'b1001, 1'b0);
        rst_n = 1'b0; bus_if.req = 4'h0;
        tick(); chk_all("mid_rst", 1'b0, 2'd0, 4'b0000, 1'b0);
        rst_n = 1'b1;
        tick(); chk_all("mid_after", 1'b0, 2'd0, 4'b0000, 1'b0);

        $display("%0d/%0d checks passed", total - failed, total);
        $finish;
    end
endmodule
